decode_stage: RTL

Instruction decode and issue stage of the nRISC pipeline, directly upstream of the register bank. Accepts 9-bit instructions over a valid/ready handshake and registers the decoded fields into a one-entry issue buffer. The buffer drives the register bank read addresses and the write destination/enable carried to execute. An 8-entry scoreboard stalls issue while a source or destination register still has a write in flight.

---
 rtl/decode_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// nRISC decode/issue stage: one-entry issue buffer plus an 8-entry write scoreboard.
// Optional DECODE_STALL_COUNTER_EN adds a saturating stall_count output.
module decode_stage #(
    parameter int NREGS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [8:0] instr,
    output logic       instr_ready,
    output logic       ex_valid,
    input  logic       ex_ready,
    output logic [2:0] ex_opcode,
    output logic [2:0] reg_read_addr_1,
    output logic [2:0] reg_read_addr_2,
    output logic [2:0] ex_dest,
    output logic       ex_write_enable,
    output logic [2:0] ex_imm,
    input  logic       wb_valid,
    input  logic [2:0] wb_dest
`ifdef DECODE_STALL_COUNTER_EN
    ,
    output logic [15:0] stall_count
`endif
);

    logic [2:0]       opcode;
    logic [2:0]       ra;
    logic [2:0]       rb;
    logic             reads_ra;
    logic             reads_rb;
    logic             writes;
    logic             hazard;
    logic             issue;
    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_eff;
    logic [NREGS-1:0] wb_clear;
    logic [NREGS-1:0] sb_set;

    assign opcode = instr[8:6];
    assign ra     = instr[5:3];
    assign rb     = instr[2:0];

    // LI reads nothing, LW reads only rb; r0 writes are dropped so they never mark the scoreboard
    assign reads_ra = (opcode[2:1] != 2'b10);
    assign reads_rb = (opcode != 3'd4);
    assign writes   = (opcode <= 3'd5) && (ra != 3'd0);

    always_comb begin
        wb_clear = '0;
        if (wb_valid) begin
            wb_clear[wb_dest] = 1'b1;
        end
    end

    always_comb begin
        sb_set = '0;
        if (issue && writes) begin
            sb_set[ra] = 1'b1;
        end
    end

    // A same-cycle writeback already frees its register for the hazard check
    assign sb_eff = sb & ~wb_clear;

    assign hazard = (reads_ra && sb_eff[ra]) ||
                    (reads_rb && sb_eff[rb]) ||
                    (writes && sb_eff[ra]);

    assign instr_ready = reset && !hazard && (!ex_valid || ex_ready);
    assign issue       = instr_valid && instr_ready;

    // Set wins over a same-register clear; bit 0 is forced low for the hard-zero register
    always_ff @(posedge clock) begin
        if (!reset) begin
            sb <= '0;
        end else begin
            sb <= (sb_eff | sb_set) & {{(NREGS-1){1'b1}}, 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_valid        <= 1'b0;
            ex_opcode       <= 3'd0;
            reg_read_addr_1 <= 3'd0;
            reg_read_addr_2 <= 3'd0;
            ex_dest         <= 3'd0;
            ex_write_enable <= 1'b0;
            ex_imm          <= 3'd0;
        end else if (issue) begin
            ex_valid        <= 1'b1;
            ex_opcode       <= opcode;
            reg_read_addr_1 <= ra;
            reg_read_addr_2 <= rb;
            ex_dest         <= ra;
            ex_write_enable <= writes;
            ex_imm          <= rb;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

`ifdef DECODE_STALL_COUNTER_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if (instr_valid && !instr_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
